// File: rtl/comb_response_logger_if.sv
// Record stream from the response logger to its consumer.
// The master presents show-ahead records; the slave accepts them with out_ready.
interface comb_response_logger_if #(
   parameter int WIDTH    = 3,
   parameter int TS_WIDTH = 16
);
   logic                      out_valid;
   logic                      out_ready;
   logic [TS_WIDTH+WIDTH-1:0] out_data;

   modport master (output out_valid, output out_data, input out_ready);
   modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/comb_response_logger.sv
// Samples a response vector and logs every change as a {timestamp, value} record.
// Records queue in a show-ahead FIFO; events that find it full are dropped and counted.
module comb_response_logger #(
   parameter int WIDTH    = 3,
   parameter int TS_WIDTH = 16,
   parameter int DEPTH    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [WIDTH-1:0]         resp_in,
   comb_response_logger_if.master   out_bus,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [7:0]               drop_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   state_t                    state_q, state_d;
   logic [WIDTH-1:0]          sync1, sync2, prev;
   logic [TS_WIDTH-1:0]       ts;
   logic                      ev_valid, prev_load;
   logic                      push, pop, drop;
   logic [AW-1:0]             wr_ptr, rd_ptr;
   logic [TS_WIDTH+WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= resp_in;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         prev    <= '0;
         ts      <= '0;
      end else begin
         state_q <= state_d;
         if (prev_load)
            prev <= sync2;
         // Clearing on the way out of RUN keeps ts at 0 for the whole IDLE stay.
         if (state_q == RUN && enable)
            ts <= ts + TS_WIDTH'(1);
         else
            ts <= '0;
      end
   end

   always_comb begin
      state_d   = state_q;
      ev_valid  = 1'b0;
      prev_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable)
               state_d = PRIME;
         end
         PRIME: begin
            ev_valid  = 1'b1;
            prev_load = 1'b1;
            state_d   = enable ? RUN : IDLE;
         end
         RUN: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (sync2 != prev) begin
               ev_valid  = 1'b1;
               prev_load = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign pop  = out_bus.out_valid && out_bus.out_ready;
   assign push = ev_valid && ((fifo_count < FULL) || pop);
   assign drop = ev_valid && !push;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {ts, sync2};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         drop_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
         if (drop && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
      end
   end

   assign out_bus.out_valid = (fifo_count != '0);
   assign out_bus.out_data  = out_bus.out_valid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_comb_response_logger.sv
// Randomized and directed bench for comb_response_logger with a session-level
// reference model feeding a scoreboard queue drained by an independent monitor.
module tb_comb_response_logger;
   localparam int W   = 3;
   localparam int TSW = 4;
   localparam int D   = 8;
   localparam int CW  = $clog2(D) + 1;

   logic           clk = 1'b0;
   logic           rst;
   logic           enable;
   logic [W-1:0]   resp_in;
   logic [CW-1:0]  fifo_count;
   logic [7:0]     drop_count;

   comb_response_logger_if #(.WIDTH(W), .TS_WIDTH(TSW)) bus ();

   comb_response_logger #(.WIDTH(W), .TS_WIDTH(TSW), .DEPTH(D)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .resp_in    (resp_in),
      .out_bus    (bus.master),
      .fifo_count (fifo_count),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: a logging session starts the cycle after enable is seen,
   // its first cycle records the sampled value, later cycles record changes
   // stamped with (session age - 1) modulo 2^TSW.
   logic [TSW+W-1:0] sb_q [$];
   int               m_age   = -1;
   int               m_count = 0;
   int               m_drops = 0;
   logic [W-1:0]     m_lag1  = '0;
   logic [W-1:0]     m_lag2  = '0;
   logic [W-1:0]     m_last  = '0;
   logic             m_ev, m_pop, m_push;
   logic [TSW-1:0]   m_ts;
   int               m_next;

   always @(posedge clk) begin
      if (rst) begin
         m_age = -1; m_count = 0; m_drops = 0;
         m_lag1 = '0; m_lag2 = '0; m_last = '0;
         sb_q.delete();
      end else begin
         m_ev = 1'b0;
         m_ts = '0;
         if (m_age < 0) begin
            m_next = enable ? 0 : -1;
         end else if (m_age == 0) begin
            m_ev   = 1'b1;
            m_last = m_lag2;
            m_next = enable ? 1 : -1;
         end else if (!enable) begin
            m_next = -1;
         end else begin
            if (m_lag2 != m_last) begin
               m_ev   = 1'b1;
               m_ts   = TSW'(m_age - 1);
               m_last = m_lag2;
            end
            m_next = m_age + 1;
         end
         m_pop  = (m_count > 0) && bus.out_ready;
         m_push = m_ev && ((m_count < D) || m_pop);
         m_count = m_count + int'(m_push) - int'(m_pop);
         if (m_ev && !m_push && m_drops < 255)
            m_drops++;
         if (m_push)
            sb_q.push_back({m_ts, m_lag2});
         m_lag2 = m_lag1;
         m_lag1 = resp_in;
         m_age  = m_next;
      end
   end

   // Monitor: compares status against the model and the head record against the scoreboard.
   always @(negedge clk) begin
      check_output("fifo_count", 32'(fifo_count), 32'(m_count));
      check_output("drop_count", 32'(drop_count), 32'(m_drops));
      check_output("out_valid", 32'(bus.out_valid), 32'(m_count != 0));
      if (!bus.out_valid) begin
         check_output("idle_data", 32'(bus.out_data), 32'd0);
      end else if (sb_q.size() == 0) begin
         check_output("head_present", 32'd0, 32'd1);
      end else begin
         check_output("head_data", 32'(bus.out_data), 32'(sb_q[0]));
         if (bus.out_ready)
            void'(sb_q.pop_front());
      end
   end

   task automatic apply_stimulus(input logic r, input logic en, input logic [W-1:0] v,
                                 input logic rdy, input int cycles);
      rst           = r;
      enable        = en;
      resp_in       = v;
      bus.out_ready = rdy;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [W-1:0] v;

   initial begin
      rst = 1'b1; enable = 1'b0; resp_in = '0; bus.out_ready = 1'b0;
      @(posedge clk); #1;

      // Reset, then prime with a steady 101.
      apply_stimulus(1'b1, 1'b0, 3'b000, 1'b0, 2);
      apply_stimulus(1'b0, 1'b0, 3'b101, 1'b0, 3);
      apply_stimulus(1'b0, 1'b1, 3'b101, 1'b0, 6);
      @(negedge clk);
      check_output("prime_count", 32'(fifo_count), 32'd1);
      check_output("prime_record", 32'(bus.out_data), 32'h05);
      @(posedge clk); #1;

      // Change stream with a draining consumer.
      apply_stimulus(1'b0, 1'b1, 3'b101, 1'b1, 4);
      apply_stimulus(1'b0, 1'b1, 3'b011, 1'b1, 5);
      apply_stimulus(1'b0, 1'b1, 3'b110, 1'b1, 6);

      // Overflow: prime plus nine changes into an undrained FIFO.
      apply_stimulus(1'b1, 1'b0, 3'b000, 1'b0, 1);
      apply_stimulus(1'b0, 1'b1, 3'b000, 1'b0, 4);
      v = '0;
      for (int i = 0; i < 9; i++) begin
         v[0] = ~v[0];
         apply_stimulus(1'b0, 1'b1, v, 1'b0, 1);
      end
      apply_stimulus(1'b0, 1'b1, v, 1'b0, 4);
      @(negedge clk);
      check_output("overflow_count", 32'(fifo_count), 32'd8);
      check_output("overflow_drops", 32'(drop_count), 32'd2);
      @(posedge clk); #1;

      // Full FIFO: the event lands in the same cycle as a pop.
      v[1] = ~v[1];
      apply_stimulus(1'b0, 1'b1, v, 1'b0, 2);
      apply_stimulus(1'b0, 1'b1, v, 1'b1, 1);
      apply_stimulus(1'b0, 1'b1, v, 1'b0, 3);
      @(negedge clk);
      check_output("pushpop_count", 32'(fifo_count), 32'd8);
      check_output("pushpop_drops", 32'(drop_count), 32'd2);
      @(posedge clk); #1;

      // Drop counter saturation, then drain.
      for (int i = 0; i < 300; i++) begin
         v[2] = ~v[2];
         apply_stimulus(1'b0, 1'b1, v, 1'b0, 1);
      end
      apply_stimulus(1'b0, 1'b1, v, 1'b0, 4);
      @(negedge clk);
      check_output("drop_saturate", 32'(drop_count), 32'd255);
      @(posedge clk); #1;
      apply_stimulus(1'b0, 1'b1, v, 1'b1, 12);

      // Timestamp wrap with a bit0 toggle every 6 cycles.
      apply_stimulus(1'b1, 1'b0, 3'b000, 1'b1, 1);
      v = '0;
      apply_stimulus(1'b0, 1'b1, v, 1'b1, 3);
      for (int i = 0; i < 5; i++) begin
         v[0] = ~v[0];
         apply_stimulus(1'b0, 1'b1, v, 1'b1, 6);
      end

      // Reset with records pending, then a fresh prime.
      apply_stimulus(1'b0, 1'b1, 3'b010, 1'b0, 2);
      apply_stimulus(1'b0, 1'b1, 3'b111, 1'b0, 4);
      apply_stimulus(1'b1, 1'b1, 3'b111, 1'b0, 1);
      @(negedge clk);
      check_output("rst_valid", 32'(bus.out_valid), 32'd0);
      check_output("rst_count", 32'(fifo_count), 32'd0);
      check_output("rst_drops", 32'(drop_count), 32'd0);
      @(posedge clk); #1;
      apply_stimulus(1'b0, 1'b1, 3'b111, 1'b1, 6);

      // Disable mid-run, change inputs, re-enable.
      apply_stimulus(1'b0, 1'b0, 3'b001, 1'b1, 8);
      apply_stimulus(1'b0, 1'b1, 3'b001, 1'b1, 8);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic r, en, rdy;
         r   = ($urandom_range(0, 199) == 0);
         en  = ($urandom_range(0, 15) != 0);
         rdy = ($urandom_range(0, 3) != 0) && (i % 400 < 300);
         if ($urandom_range(0, 2) == 0)
            v = W'($urandom_range(0, 7));
         apply_stimulus(r, en, v, rdy, 1);
      end

      apply_stimulus(1'b0, 1'b1, v, 1'b1, 16);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/comb_response_logger.md
# comb_response_logger

Downstream capture stage for the combinational logic under test. It samples the DUT's output vector (the `w_5_*` nets) on a clock and detects every change in it. Each change is logged as a {timestamp, value} record in a small FIFO, which a checker or host drains through a valid/ready handshake. Events that arrive while the FIFO is full are dropped and counted, never silently lost.

## Interface
- `WIDTH`, 3: width of the monitored response vector.
- `TS_WIDTH`, 16: timestamp counter width; wraps modulo 2^TS_WIDTH.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `clk`  input  1  single clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `enable`  input  1  logging enable.
- `resp_in`  input  WIDTH  DUT response vector (asynchronous to `clk`).
- `out_valid`  output  1  head record available.
- `out_ready`  input  1  consumer accepts head record.
- `out_data`  output  TS_WIDTH+WIDTH  head record, {timestamp, value}; value in the LSBs.
- `fifo_count`  output  log2(DEPTH)+1  occupied entries, 0..DEPTH.
- `drop_count`  output  8  dropped events; saturates at 255.

## Operation
- **Input synchronizer.** Two flops, `sync1` then `sync2`. Both reset to 0. `sync2` is the sampled value.
- **State machine.** States are IDLE, PRIME and RUN. Reset state is IDLE.
  - IDLE: timestamp held at 0; no events generated. If `enable`=1, go to PRIME.
  - PRIME: one cycle. Unconditionally generates an event with value `sync2` and timestamp 0. Loads `prev` ← `sync2`. Go to RUN; if `enable`=0, go to IDLE instead (the event is still generated).
  - RUN: when `sync2` ≠ `prev`, generate an event {ts, `sync2`} and load `prev` ← `sync2`. If `enable`=0, go to IDLE with no event that cycle.
- **Timestamp.** `ts` is 0 in IDLE and PRIME. It increments by 1 on every clock in RUN and wraps from 2^TS_WIDTH−1 to 0.
  - The recorded timestamp is the value of `ts` in the cycle the event is generated, before that clock's increment.
- **FIFO.**
  - Push: an event is pushed if `fifo_count` < DEPTH, or if a pop occurs in the same cycle.
  - Drop: otherwise the event is discarded and `drop_count` increments (saturating at 255). `drop_count` clears only on `rst`.
  - Pop: occurs when `out_valid` and `out_ready` are both 1.
  - Simultaneous push and pop: `fifo_count` is unchanged. At full, the pushed record occupies the freed slot. When empty there is no pop, so push-only applies.
  - Pointers are log2(DEPTH) bits wide and wrap naturally.
- **Output.** `out_valid` = (`fifo_count` ≠ 0). `out_data` shows the head entry (show-ahead) and is forced to 0 when `out_valid`=0.
  - `out_data` must hold stable while `out_valid`=1 and `out_ready`=0.
- **Reset values.** `rst` forces all of the following, with the FIFO contents treated as discarded:
  - `out_valid`=0, `out_data`=0, `fifo_count`=0, `drop_count`=0;
  - state IDLE, `ts`=0, `prev`=0, `sync1`/`sync2`=0.
- **Reset mid-operation.** Reset wins over any simultaneous push or pop. A pending record being read is lost.

## Timing
- **Capture latency.** If `resp_in` changes before edge k, `sync2` shows the new value after edge k+1, the event is pushed at edge k+2, and `out_valid` rises after edge k+2.
- **Prime latency.** If `enable` rises before edge k, the state is PRIME after edge k and the prime record is pushed at edge k+1.
- **Pulse capture.** A `resp_in` pulse held for ≥1 full clock period is captured as two events, the change and the return. Shorter pulses may be missed.
- **Throughput.** One event push and one pop per cycle, sustained.
- **Ready timing.** `out_ready` may be asserted in the same cycle `out_valid` rises. There is no combinational path from `out_ready` to `out_valid`.

## Test plan
- **Reset and prime.** Assert `rst` for 2 cycles, then `enable`=1 with `resp_in`=3'b101 held steady.
  - Required: exactly one record {0, 101}; `fifo_count`=1; no further records.
- **Change stream.** After priming, drive `resp_in` 101→011 (at RUN cycle 4) →110 (at RUN cycle 9), with `out_ready`=1.
  - Required: records with values 011 and 110, timestamps differing by 5, each visible 2 cycles after its input change.
- **Overflow.** DEPTH=8, `out_ready`=0, generate 10 events (prime plus 9 changes).
  - Required: `fifo_count`=8; `drop_count`=2; the first 8 records drain in order.
  - Further: 300 additional drops leave `drop_count`=255.
- **Full with simultaneous push and pop.** FIFO full, `out_ready`=1, and an event in the same cycle.
  - Required: `fifo_count` stays 8, `drop_count` unchanged, the new record appears last.
- **Timestamp wrap.** TS_WIDTH=4, toggle `resp_in` bit0 every 6 cycles.
  - Required: timestamps 0 (prime), then 6, 12, 2, 8 (mod 16).
- **Reset and disable mid-operation.**
  - With 3 records queued and `out_valid`=1, pulse `rst` for 1 cycle. Required: `out_valid`=0, `fifo_count`=0, `drop_count`=0 the next cycle, and a fresh prime on the next `enable`.
  - Deassert `enable` while in RUN. Required: no records until re-enable, then a prime record with timestamp 0.
